// File: rtl/fifo_rd_arb.sv
// Multi-channel FIFO read controller: round-robin pop arbitration and read pointers.
// Optional per-channel grant counters are enabled with FIFO_RD_STATS_EN.
module fifo_rd_arb #(
    parameter int NUM_CH   = 4,
    parameter int MEM_SIZE = 4,
    parameter int PTR_L    = 3,
    parameter int CH_W     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_rd,
    input  logic [NUM_CH-1:0]       fifo_empty,
    input  logic [NUM_CH-1:0]       flush,
    output logic [NUM_CH*PTR_L-1:0] rd_ptr,
    output logic [NUM_CH-1:0]       pop,
    output logic [CH_W-1:0]         ch_sel,
`ifdef FIFO_RD_STATS_EN
    output logic [NUM_CH*16-1:0]    rd_count,
`endif
    output logic                    rd_valid
);

    logic [PTR_L-1:0]  ptr_q [NUM_CH];
    logic [PTR_L-1:0]  ptr_d [NUM_CH];
    logic [NUM_CH-1:0] pop_q, pop_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;
    logic              rd_valid_q, rd_valid_d;

    logic [NUM_CH-1:0] eligible;
    logic              hi_found, lo_found, grant_ok;
    logic [CH_W-1:0]   hi_idx, lo_idx, grant;

    // Round-robin: lowest eligible index above last_grant, else lowest at or below it.
    always_comb begin
        eligible = ~fifo_empty & ~flush;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (eligible[CH_W'(i)]) begin
                if (CH_W'(i) > last_grant_q) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = CH_W'(i);
                    end
                end else if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = CH_W'(i);
                end
            end
        end
        grant_ok = fifo_rd && (hi_found || lo_found);
        grant    = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        pop_d        = grant_ok ? (NUM_CH'(1) << grant) : '0;
        rd_valid_d   = grant_ok;
        ch_sel_d     = grant_ok ? grant : ch_sel_q;
        last_grant_d = grant_ok ? grant : last_grant_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ptr_d[i] = ptr_q[i];
            if (flush[i]) begin
                ptr_d[i] = '0;
            end else if (grant_ok && grant == CH_W'(i)) begin
                ptr_d[i] = (ptr_q[i] == PTR_L'(MEM_SIZE - 1)) ? '0 : ptr_q[i] + PTR_L'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                ptr_q[i] <= '0;
            end
            pop_q        <= '0;
            ch_sel_q     <= '0;
            rd_valid_q   <= 1'b0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else begin
            ptr_q        <= ptr_d;
            pop_q        <= pop_d;
            ch_sel_q     <= ch_sel_d;
            rd_valid_q   <= rd_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        rd_ptr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            rd_ptr[i*PTR_L +: PTR_L] = ptr_q[i];
        end
    end

    assign pop      = pop_q;
    assign ch_sel   = ch_sel_q;
    assign rd_valid = rd_valid_q;

`ifdef FIFO_RD_STATS_EN
    logic [15:0] cnt_q [NUM_CH];
    logic [15:0] cnt_d [NUM_CH];

    always_comb begin
        rd_count = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush[i]) begin
                cnt_d[i] = '0;
            end else if (grant_ok && grant == CH_W'(i) && cnt_q[i] != 16'hFFFF) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
            rd_count[i*16 +: 16] = cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Directed table-driven bench for fifo_rd_arb (MEM_SIZE=5 to exercise non-power-of-two wrap).
module tb_fifo_rd_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        fifo_rd;
    logic [3:0]  fifo_empty;
    logic [3:0]  flush;
    logic [11:0] rd_ptr;
    logic [3:0]  pop;
    logic [1:0]  ch_sel;
    logic        rd_valid;
`ifdef FIFO_RD_STATS_EN
    logic [63:0] rd_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    fifo_rd_arb #(.NUM_CH(4), .MEM_SIZE(5), .PTR_L(3), .CH_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_rd    (fifo_rd),
        .fifo_empty (fifo_empty),
        .flush      (flush),
        .rd_ptr     (rd_ptr),
        .pop        (pop),
        .ch_sel     (ch_sel),
`ifdef FIFO_RD_STATS_EN
        .rd_count   (rd_count),
`endif
        .rd_valid   (rd_valid)
    );

    typedef struct {
        logic        rst;
        logic        rd;
        logic [3:0]  emp;
        logic [3:0]  fl;
        logic [3:0]  pop;
        logic [1:0]  ch;
        logic        vld;
        logic [11:0] ptr;
    } vec_t;

    vec_t tv[$];

    function automatic logic [11:0] P(input int p3, input int p2, input int p1, input int p0);
        return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
    endfunction

    task automatic add(input logic rst, input logic rd, input logic [3:0] emp, input logic [3:0] fl,
                       input logic [3:0] ep, input logic [1:0] ech, input logic ev, input logic [11:0] eptr);
        vec_t v;
        v.rst = rst; v.rd = rd; v.emp = emp; v.fl = fl;
        v.pop = ep; v.ch = ech; v.vld = ev; v.ptr = eptr;
        tv.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h want %0h", name, idx, got, exp);
    endtask

    task automatic drive(input logic rst, input logic rd, input logic [3:0] emp, input logic [3:0] fl);
        reset = rst; fifo_rd = rd; fifo_empty = emp; flush = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; fifo_rd = 1'b0; fifo_empty = '1; flush = '0;

        // reset held two cycles, then released idle
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, P(0,0,0,0));
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, P(0,0,0,0));
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, P(0,0,0,0));
        // fairness: 0,1,2,3,0,1,2,3
        add(0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1, P(0,0,0,1));
        add(0, 1, 4'b0000, 4'b0000, 4'b0010, 1, 1, P(0,0,1,1));
        add(0, 1, 4'b0000, 4'b0000, 4'b0100, 2, 1, P(0,1,1,1));
        add(0, 1, 4'b0000, 4'b0000, 4'b1000, 3, 1, P(1,1,1,1));
        add(0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1, P(1,1,1,2));
        add(0, 1, 4'b0000, 4'b0000, 4'b0010, 1, 1, P(1,1,2,2));
        add(0, 1, 4'b0000, 4'b0000, 4'b0100, 2, 1, P(1,2,2,2));
        add(0, 1, 4'b0000, 4'b0000, 4'b1000, 3, 1, P(2,2,2,2));
        // reset, then only channel 2 non-empty: pointer 1,2,3,4,0,1
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, P(0,0,0,0));
        add(0, 1, 4'b1011, 4'b0000, 4'b0100, 2, 1, P(0,1,0,0));
        add(0, 1, 4'b1011, 4'b0000, 4'b0100, 2, 1, P(0,2,0,0));
        add(0, 1, 4'b1011, 4'b0000, 4'b0100, 2, 1, P(0,3,0,0));
        add(0, 1, 4'b1011, 4'b0000, 4'b0100, 2, 1, P(0,4,0,0));
        add(0, 1, 4'b1011, 4'b0000, 4'b0100, 2, 1, P(0,0,0,0));
        add(0, 1, 4'b1011, 4'b0000, 4'b0100, 2, 1, P(0,1,0,0));
        // all empty, then no request: ch_sel holds 2
        add(0, 1, 4'b1111, 4'b0000, 4'b0000, 2, 0, P(0,1,0,0));
        add(0, 0, 4'b0000, 4'b0000, 4'b0000, 2, 0, P(0,1,0,0));
        // bring channel 1 to 3, then flush collides with a read
        add(0, 1, 4'b1101, 4'b0000, 4'b0010, 1, 1, P(0,1,1,0));
        add(0, 1, 4'b1101, 4'b0000, 4'b0010, 1, 1, P(0,1,2,0));
        add(0, 1, 4'b1101, 4'b0000, 4'b0010, 1, 1, P(0,1,3,0));
        add(0, 1, 4'b1101, 4'b0010, 4'b0000, 1, 0, P(0,1,0,0));
        add(0, 1, 4'b1101, 4'b0000, 4'b0010, 1, 1, P(0,1,1,0));
        // flush ch1 while others arbitrate: ch2 granted, last_grant untouched by flush
        add(0, 1, 4'b0000, 4'b0010, 4'b0100, 2, 1, P(0,2,0,0));
        add(0, 1, 4'b0000, 4'b0000, 4'b1000, 3, 1, P(1,2,0,0));
        // reset mid-operation, then channel 0 has first priority again
        add(1, 1, 4'b0000, 4'b0000, 4'b0000, 0, 0, P(0,0,0,0));
        add(0, 1, 4'b0000, 4'b0000, 4'b0001, 0, 1, P(0,0,0,1));

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].rd, tv[i].emp, tv[i].fl);
            check("pop",      i, 64'(pop),      64'(tv[i].pop));
            check("ch_sel",   i, 64'(ch_sel),   64'(tv[i].ch));
            check("rd_valid", i, 64'(rd_valid), 64'(tv[i].vld));
            check("rd_ptr",   i, 64'(rd_ptr),   64'(tv[i].ptr));
        end

`ifdef FIFO_RD_STATS_EN
        drive(1, 0, 4'b1111, 4'b0000);
        check("cnt_reset", 0, rd_count, 64'd0);
        for (int k = 0; k < 3; k++) drive(0, 1, 4'b1110, 4'b0000);
        check("cnt_three", 0, 64'(rd_count[15:0]), 64'd3);
        drive(0, 0, 4'b1110, 4'b0001);
        check("cnt_flush", 0, 64'(rd_count[15:0]), 64'd0);
        dut.cnt_q[0] = 16'hFFFF;
        drive(0, 1, 4'b1110, 4'b0000);
        check("cnt_sat", 0, 64'(rd_count[15:0]), 64'hFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arb.md
Name: fifo_rd_arb

Overview:
Parametrised multi-channel FIFO read controller. Owns the read pointers of NUM_CH independent FIFO memories and serves a single downstream read request per cycle. Picks one non-empty channel by round-robin arbitration, issues a one-cycle pop to that channel and advances only that channel's pointer. Sits between the per-channel FIFO memories/status logic and the shared downstream consumer.

Parameters:
NUM_CH, 4, number of FIFO channels served (>=2)
MEM_SIZE, 4, entries per channel memory; need not be a power of two
PTR_L, 3, read pointer width; 2^PTR_L >= MEM_SIZE
CH_W, 2, channel index width; 2^CH_W >= NUM_CH

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous reset, active-high
fifo_rd  in  1  downstream requests one word this cycle
fifo_empty  in  NUM_CH  per-channel empty flag, bit i = channel i
flush  in  NUM_CH  per-channel synchronous pointer clear, bit i = channel i
rd_ptr  out  NUM_CH*PTR_L  concatenated pointers; channel i at bits [i*PTR_L +: PTR_L]
pop  out  NUM_CH  one-hot registered pop strobe
ch_sel  out  CH_W  index of channel popped this cycle
rd_valid  out  1  high when pop is non-zero

Behaviour:
- Reset (reset=1 at posedge): every rd_ptr=0, pop=0, ch_sel=0, rd_valid=0, internal last_grant=NUM_CH-1, so channel 0 has first priority after reset. Reset overrides all other inputs.
- Eligibility: channel i is eligible when fifo_empty[i]=0 and flush[i]=0.
- Grant: when fifo_rd=1 and at least one channel is eligible, grant the first eligible channel found by searching upward from last_grant+1, wrapping modulo NUM_CH.
- Grant outputs, registered and visible the cycle after the request: pop[g]=1, all other pop bits 0, ch_sel=g, rd_valid=1, last_grant=g.
- No grant (fifo_rd=0, or no channel eligible): pop=0, rd_valid=0. ch_sel and last_grant hold their values.
- Pointer advance: on grant, rd_ptr[g] becomes rd_ptr[g]+1. If rd_ptr[g]==MEM_SIZE-1, it wraps to 0. Arithmetic is in PTR_L bits.
- Only the granted channel's pointer changes in a cycle.
- Flush: flush[i]=1 sets rd_ptr[i]=0 on the next edge. Flush takes precedence over pop for channel i; a flushed channel is never granted that cycle. Other channels arbitrate normally in the same cycle. Flush does not modify last_grant.
- Back-to-back: fifo_rd held high with a channel staying non-empty gives one pop per cycle. Fairness: among continuously eligible channels, no channel is granted twice before every other one has been granted once.
- fifo_empty is trusted as sampled. No look-ahead for the pop issued in the previous cycle; the FIFO status logic must update empty combinationally from pointers.
- Reset mid-operation: any pending pop is dropped; outputs return to reset values on that edge.

Optional Feature:
Macro FIFO_RD_STATS_EN.
- Defined: adds output port rd_count of width NUM_CH*16, one per-channel count of grants.
- Each counter increments by 1 on a grant to its channel and saturates at 16'hFFFF.
- Counters clear on reset and on flush[i] for channel i.
- Not defined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: reset=1 for 2 cycles, then 0 -> all rd_ptr=0, pop=0, rd_valid=0, ch_sel=0.
- Fairness: NUM_CH=4, all fifo_empty=0, fifo_rd=1 for 8 cycles -> ch_sel sequence 0,1,2,3,0,1,2,3; pop one-hot each cycle.
- Wrap, non-power-of-two depth: MEM_SIZE=5, only channel 2 non-empty, 6 reads -> rd_ptr[2] goes 1,2,3,4,0,1; other pointers stay 0.
- Skip empty / idle: fifo_empty=4'b1011, fifo_rd=1 -> only channel 2 granted. Then fifo_empty=4'b1111 -> pop=0, rd_valid=0, ch_sel holds 2.
- Flush vs pop: rd_ptr[1]=3, only channel 1 non-empty, fifo_rd=1 and flush=4'b0010 in the same cycle -> rd_ptr[1]=0, pop=0. The next read grants channel 1 with rd_ptr[1]=1.
- Stats (FIFO_RD_STATS_EN): 3 grants to channel 0 -> rd_count[0]=3. Then flush[0] -> rd_count[0]=0. Forced counter value 16'hFFFF plus one more grant -> stays 16'hFFFF.
